// File: rtl/nukv_fifo_ng_pkg.sv
// nukv_fifo_ng_pkg: shared constants and helpers for the nukv FIFO
package nukv_fifo_ng_pkg;
  localparam logic [1:0] FIFO_INIT_CYCLES = 2'd2;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/nukv_fifo_ng_sdp_ram.sv
// nukv_fifo_ng_sdp_ram: simple dual-port RAM, one write port, registered read port with enable
module nukv_fifo_ng_sdp_ram #(
  parameter int ADDR_BITS = 9,
  parameter int WIDTH = 65
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);
  logic [WIDTH-1:0] mem [2**ADDR_BITS];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/nukv_fifo_ng.sv
// nukv_fifo_ng: FWFT FIFO on inferred block RAM with almost-full, fill count
// and optional store-and-forward packet gating.
module nukv_fifo_ng
  import nukv_fifo_ng_pkg::*;
#(
  parameter int ADDR_BITS = 9,
  parameter int DATA_SIZE = 64,
  parameter int AFULL_MARGIN = 8,
  parameter int PACKET_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_SIZE-1:0] s_axis_tdata,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic                 s_axis_talmostfull,
  output logic [DATA_SIZE-1:0] m_axis_tdata,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [ADDR_BITS:0]   fill_count,
  output logic                 err_oversize
);
  localparam int CW = ADDR_BITS + 1;
  localparam logic [ADDR_BITS:0] FULL = CW'(2**ADDR_BITS);
  localparam logic [ADDR_BITS:0] AFULL_AT = CW'(2**ADDR_BITS - AFULL_MARGIN);
  logic [ADDR_BITS-1:0] wr_ptr, rd_ptr, commit_ptr;
  logic [ADDR_BITS:0] ram_count, committed;
  logic [1:0] init_cnt;
  logic [DATA_SIZE:0] rdata;
  logic out_valid, init_done, wr, rd, avail, force_commit;
  assign init_done = init_cnt == FIFO_INIT_CYCLES;
  assign s_axis_tready = init_done && ram_count != FULL;
  assign s_axis_talmostfull = ram_count >= AFULL_AT;
  assign wr = s_axis_tvalid && s_axis_tready;
  // committed disambiguates rd_ptr==commit_ptr between "nothing committed" and "whole RAM committed"
  assign avail = PACKET_MODE != 0 ? (rd_ptr != commit_ptr || committed != '0) : ram_count != '0;
  assign rd = init_done && avail && (!out_valid || m_axis_tready);
  assign force_commit = PACKET_MODE != 0 && ram_count == FULL && committed == '0;
  assign m_axis_tvalid = out_valid;
  assign {m_axis_tlast, m_axis_tdata} = rdata;
  assign fill_count = ram_count + CW'(out_valid);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      commit_ptr <= '0;
      ram_count <= '0;
      committed <= '0;
      init_cnt <= '0;
      out_valid <= 1'b0;
      err_oversize <= 1'b0;
    end else begin
      if (!init_done) init_cnt <= init_cnt + 2'd1;
      if (wr) wr_ptr <= wr_ptr + ADDR_BITS'(1);
      if (rd) rd_ptr <= rd_ptr + ADDR_BITS'(1);
      ram_count <= ram_count + CW'(wr) - CW'(rd);
      out_valid <= rd ? 1'b1 : (m_axis_tready ? 1'b0 : out_valid);
      if (PACKET_MODE != 0) begin
        if (force_commit) begin
          commit_ptr <= wr_ptr;
          committed <= ram_count;
          err_oversize <= 1'b1;
        end else if (wr && s_axis_tlast) begin
          commit_ptr <= wr_ptr + ADDR_BITS'(1);
          committed <= ram_count + CW'(1) - CW'(rd);
        end else begin
          committed <= committed - CW'(rd);
        end
      end
    end
  nukv_fifo_ng_sdp_ram #(.ADDR_BITS(ADDR_BITS), .WIDTH(DATA_SIZE + 1)) u_ram (
    .clk(clk),
    .rst_n(rst_n),
    .we(wr),
    .waddr(wr_ptr),
    .wdata({s_axis_tlast, s_axis_tdata}),
    .re(rd),
    .raddr(rd_ptr),
    .rdata(rdata)
  );
endmodule
